control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
- REQ-001 SHALL have no parameters; opcodes are fixed local constants.
- REQ-002 SHALL have port `clk`, input, 1 bit: sole clock, rising edge.
- REQ-003 SHALL have port `reset`, input, 1 bit: asynchronous, active-high.
- REQ-004 SHALL have port `IR`, input, 8 bits: current opcode from the instruction register.
- REQ-005 SHALL have port `CCR_Result`, input, 4 bits: registered flags {N,Z,V,C}.
- REQ-006 SHALL have port `IR_Load`, output, 1 bit: IR <= Bus2.
- REQ-007 SHALL have port `MAR_Load`, output, 1 bit: MAR <= Bus2.
- REQ-008 SHALL have port `PC_Load`, output, 1 bit: PC <= Bus2.
- REQ-009 SHALL have port `PC_Inc`, output, 1 bit: PC <= PC+1.
- REQ-010 SHALL have ports `A_Load`, `B_Load`, `CCR_Load`, each output, 1 bit: register load strobes.
- REQ-011 SHALL have port `ALU_Sel`, output, 3 bits. Encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 INC, 101 DEC, 110 XOR, 111 NOT. The ALU operands are Bus1 and register B.
- REQ-012 SHALL have port `Bus1_Sel`, output, 2 bits: 00 PC, 01 A, 10 B.
- REQ-013 SHALL have port `Bus2_Sel`, output, 2 bits: 00 ALU, 01 Bus1, 10 from_memory.
- REQ-014 SHALL have port `write`, output, 1 bit: memory write strobe at the MAR address.

Function
- REQ-015 SHALL be a Moore FSM: all outputs decode from the registered state only, and every output not named in a state is 0.
- REQ-016 SHALL have state RST with all outputs 0, going to F0 on the next clock.
- REQ-017 SHALL implement the fetch sequence:
  - F0: Bus1=PC, Bus2=Bus1, MAR_Load.
  - F1: PC_Inc.
  - F2: Bus2=mem, IR_Load.
  - D3: no outputs; branch on IR.
- REQ-018 SHALL execute LDA_IMM 0x86 / LDB_IMM 0x88 as:
  - S4: MAR<=PC.
  - S5: PC_Inc.
  - S6: Bus2=mem, A_Load/B_Load.
  - Then F0. Total 7 cycles.
- REQ-019 SHALL execute LDA_DIR 0x87 / LDB_DIR 0x89 as:
  - S4: MAR<=PC.
  - S5: PC_Inc.
  - S6: Bus2=mem, MAR_Load.
  - S7: wait.
  - S8: Bus2=mem, A_Load/B_Load.
  - Then F0. Total 9 cycles.
- REQ-020 SHALL execute STA_DIR 0x96 / STB_DIR 0x97 as:
  - S4: MAR<=PC.
  - S5: PC_Inc.
  - S6: Bus2=mem, MAR_Load.
  - S7: Bus1=A/B, write=1.
  - Then F0. Total 8 cycles.
- REQ-021 SHALL execute each ALU opcode in one state S4: set ALU_Sel, Bus2=ALU, assert the destination load and CCR_Load, then go to F0. Per-opcode settings:

  | Opcode | Bus1 | ALU_Sel | Destination |
  |---|---|---|---|
  | ADD_AB 0x42 | A | ADD | A |
  | SUB_AB 0x43 | A | SUB | A |
  | AND_AB 0x44 | A | AND | A |
  | OR_AB 0x45 | A | OR | A |
  | XOR_AB 0x4A | A | XOR | A |
  | INCA 0x46 | A | INC | A |
  | DECA 0x48 | A | DEC | A |
  | NOTA 0x4B | A | NOT | A |
  | INCB 0x47 | B | INC | B |
  | DECB 0x49 | B | DEC | B |
  | NOTB 0x4C | B | NOT | B |

- REQ-022 SHALL execute BRA 0x20 as:
  - S4: MAR<=PC.
  - S5: wait.
  - S6: Bus2=mem, PC_Load.
  - Then F0. Total 7 cycles.
- REQ-023 SHALL treat a conditional branch (0x21-0x28: BMI N=1, BPL N=0, BEQ Z=1, BNE Z=0, BVS V=1, BVC V=0, BCS C=1, BCC C=0) whose condition is true in D3 exactly like BRA.
- REQ-024 SHALL, when a conditional branch condition is false, enter state S4N asserting PC_Inc only, then go to F0 (5 cycles; operand skipped).
- REQ-025 SHALL sample CCR_Result only in D3; later flag changes during execution are ignored.
- REQ-026 SHALL treat an undefined opcode as a NOP: D3 goes directly to F0 (4 cycles) and PC is not advanced.
- REQ-027 SHALL never assert write together with any load strobe, and never assert PC_Inc and PC_Load in the same state.

Reset
- REQ-028 SHALL, on reset assertion, asynchronously force state RST and drive all outputs to 0 within the same cycle, from any state including mid-instruction.
- REQ-029 SHALL hold RST while reset is high and reach F0 on the first rising clk after deassertion.

Configuration
- REQ-030 SHALL use macro CU_COND_BRANCH_EN to select conditional-branch support.
- REQ-031 SHALL, when CU_COND_BRANCH_EN is defined, implement REQ-023 and REQ-024.
- REQ-032 SHALL, when CU_COND_BRANCH_EN is undefined, execute opcodes 0x21-0x28 always via the not-taken path S4N, and ignore CCR_Result entirely; BRA is unaffected.

Verification
- REQ-033 SHALL be verified with: reset released, IR=0x86 -> state sequence RST,F0,F1,F2,D3,S4,S5,S6,F0; A_Load=1 only in S6 with Bus2_Sel=10.
- REQ-034 SHALL be verified with: IR=0x96 -> write=1 exactly one cycle, in S7, with Bus1_Sel=01; MAR_Load pulses in F0, S4 and S6.
- REQ-035 SHALL be verified with: IR=0x47 -> S4 shows Bus1_Sel=10, ALU_Sel=100, Bus2_Sel=00, B_Load=1, CCR_Load=1, A_Load=0.
- REQ-036 SHALL be verified with: IR=0x23 and CCR_Result=4'b0100 -> PC_Load in S6. IR=0x23 and CCR_Result=4'b0000 -> PC_Inc in S4N, PC_Load never asserted. Both with CU_COND_BRANCH_EN defined; undefined -> S4N in both cases.
- REQ-037 SHALL be verified with: reset asserted asynchronously in S7 of STA_DIR -> write drops to 0 before the next clk edge; F0 is reached one clock after release.
- REQ-038 SHALL be verified with: IR=0xFF -> D3 goes to F0; no strobe other than fetch strobes asserts.

Source files
------------

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore control FSM for the accumulator CPU (fetch/decode/execute).
// Optional conditional branches are enabled with `define CU_COND_BRANCH_EN.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic [2:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write
);

  localparam logic [7:0] OP_LDA_IMM = 8'h86, OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDA_DIR = 8'h87, OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96, OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD_AB = 8'h42, OP_SUB_AB = 8'h43, OP_AND_AB = 8'h44;
  localparam logic [7:0] OP_OR_AB  = 8'h45, OP_XOR_AB = 8'h4A;
  localparam logic [7:0] OP_INCA = 8'h46, OP_DECA = 8'h48, OP_NOTA = 8'h4B;
  localparam logic [7:0] OP_INCB = 8'h47, OP_DECB = 8'h49, OP_NOTB = 8'h4C;
  localparam logic [7:0] OP_BRA = 8'h20;
  localparam logic [7:0] OP_BMI = 8'h21, OP_BPL = 8'h22, OP_BEQ = 8'h23, OP_BNE = 8'h24;
  localparam logic [7:0] OP_BVS = 8'h25, OP_BVC = 8'h26, OP_BCS = 8'h27, OP_BCC = 8'h28;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_INC = 3'b100, ALU_DEC = 3'b101, ALU_XOR = 3'b110, ALU_NOT = 3'b111;

  localparam logic [1:0] B1_PC = 2'b00, B1_A = 2'b01, B1_B = 2'b10;
  localparam logic [1:0] B2_ALU = 2'b00, B2_BUS1 = 2'b01, B2_MEM = 2'b10;

  typedef enum logic [3:0] {
    ST_RST, ST_F0, ST_F1, ST_F2, ST_D3,
    ST_S4, ST_S5, ST_S6, ST_S7, ST_S8, ST_S4N
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE, CL_LD_IMM, CL_LD_DIR, CL_ST_DIR, CL_ALU, CL_BRA, CL_BCC
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic       use_b;
    logic [2:0] alu;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] op);
    dec_t d;
    d.cls   = CL_NONE;
    d.use_b = 1'b0;
    d.alu   = ALU_ADD;
    case (op)
      OP_LDA_IMM: d.cls = CL_LD_IMM;
      OP_LDB_IMM: begin d.cls = CL_LD_IMM; d.use_b = 1'b1; end
      OP_LDA_DIR: d.cls = CL_LD_DIR;
      OP_LDB_DIR: begin d.cls = CL_LD_DIR; d.use_b = 1'b1; end
      OP_STA_DIR: d.cls = CL_ST_DIR;
      OP_STB_DIR: begin d.cls = CL_ST_DIR; d.use_b = 1'b1; end
      OP_ADD_AB:  begin d.cls = CL_ALU; d.alu = ALU_ADD; end
      OP_SUB_AB:  begin d.cls = CL_ALU; d.alu = ALU_SUB; end
      OP_AND_AB:  begin d.cls = CL_ALU; d.alu = ALU_AND; end
      OP_OR_AB:   begin d.cls = CL_ALU; d.alu = ALU_OR;  end
      OP_XOR_AB:  begin d.cls = CL_ALU; d.alu = ALU_XOR; end
      OP_INCA:    begin d.cls = CL_ALU; d.alu = ALU_INC; end
      OP_DECA:    begin d.cls = CL_ALU; d.alu = ALU_DEC; end
      OP_NOTA:    begin d.cls = CL_ALU; d.alu = ALU_NOT; end
      OP_INCB:    begin d.cls = CL_ALU; d.alu = ALU_INC; d.use_b = 1'b1; end
      OP_DECB:    begin d.cls = CL_ALU; d.alu = ALU_DEC; d.use_b = 1'b1; end
      OP_NOTB:    begin d.cls = CL_ALU; d.alu = ALU_NOT; d.use_b = 1'b1; end
      OP_BRA:     d.cls = CL_BRA;
      OP_BMI, OP_BPL, OP_BEQ, OP_BNE,
      OP_BVS, OP_BVC, OP_BCS, OP_BCC: d.cls = CL_BCC;
      default:    d.cls = CL_NONE;
    endcase
    return d;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  dec_t       dec_ir, dec_q;
  logic       cond_true;

  assign dec_ir = decode(IR);
  assign dec_q  = decode(op_q);

`ifdef CU_COND_BRANCH_EN
  // Flags {N,Z,V,C}; only consulted while in D3.
  always_comb begin
    cond_true = 1'b0;
    case (IR)
      OP_BMI:  cond_true =  CCR_Result[3];
      OP_BPL:  cond_true = ~CCR_Result[3];
      OP_BEQ:  cond_true =  CCR_Result[2];
      OP_BNE:  cond_true = ~CCR_Result[2];
      OP_BVS:  cond_true =  CCR_Result[1];
      OP_BVC:  cond_true = ~CCR_Result[1];
      OP_BCS:  cond_true =  CCR_Result[0];
      OP_BCC:  cond_true = ~CCR_Result[0];
      default: cond_true = 1'b0;
    endcase
  end
`else
  logic unused_ccr;
  assign unused_ccr = ^CCR_Result;
  assign cond_true  = 1'b0;
`endif

  // The opcode is latched in D3 so execute states decode from registered state only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RST;
      op_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = (state_q == ST_D3) ? IR : op_q;
    case (state_q)
      ST_RST: state_d = ST_F0;
      ST_F0:  state_d = ST_F1;
      ST_F1:  state_d = ST_F2;
      ST_F2:  state_d = ST_D3;
      ST_D3: begin
        case (dec_ir.cls)
          CL_NONE: state_d = ST_F0;
          CL_BCC:  state_d = cond_true ? ST_S4 : ST_S4N;
          default: state_d = ST_S4;
        endcase
      end
      ST_S4:  state_d = (dec_q.cls == CL_ALU) ? ST_F0 : ST_S5;
      ST_S5:  state_d = ST_S6;
      ST_S6:  state_d = (dec_q.cls == CL_LD_DIR || dec_q.cls == CL_ST_DIR) ? ST_S7 : ST_F0;
      ST_S7:  state_d = (dec_q.cls == CL_LD_DIR) ? ST_S8 : ST_F0;
      ST_S8:  state_d = ST_F0;
      ST_S4N: state_d = ST_F0;
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    ALU_Sel  = ALU_ADD;
    Bus1_Sel = B1_PC;
    Bus2_Sel = B2_ALU;
    write    = 1'b0;
    case (state_q)
      ST_F0: begin
        Bus1_Sel = B1_PC;
        Bus2_Sel = B2_BUS1;
        MAR_Load = 1'b1;
      end
      ST_F1: PC_Inc = 1'b1;
      ST_F2: begin
        Bus2_Sel = B2_MEM;
        IR_Load  = 1'b1;
      end
      ST_S4: begin
        if (dec_q.cls == CL_ALU) begin
          ALU_Sel  = dec_q.alu;
          Bus1_Sel = dec_q.use_b ? B1_B : B1_A;
          Bus2_Sel = B2_ALU;
          A_Load   = ~dec_q.use_b;
          B_Load   = dec_q.use_b;
          CCR_Load = 1'b1;
        end else begin
          Bus1_Sel = B1_PC;
          Bus2_Sel = B2_BUS1;
          MAR_Load = 1'b1;
        end
      end
      ST_S5: PC_Inc = (dec_q.cls == CL_LD_IMM || dec_q.cls == CL_LD_DIR || dec_q.cls == CL_ST_DIR);
      ST_S6: begin
        Bus2_Sel = B2_MEM;
        case (dec_q.cls)
          CL_LD_IMM: begin A_Load = ~dec_q.use_b; B_Load = dec_q.use_b; end
          CL_LD_DIR, CL_ST_DIR: MAR_Load = 1'b1;
          CL_BRA, CL_BCC: PC_Load = 1'b1;
          default: ;
        endcase
      end
      ST_S7: begin
        if (dec_q.cls == CL_ST_DIR) begin
          Bus1_Sel = dec_q.use_b ? B1_B : B1_A;
          write    = 1'b1;
        end
      end
      ST_S8: begin
        Bus2_Sel = B2_MEM;
        A_Load   = ~dec_q.use_b;
        B_Load   = dec_q.use_b;
      end
      ST_S4N: PC_Inc = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit with a per-opcode cycle model.
module tb_control_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;

  control_unit dut (
    .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] v;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [14:0] seq[$];
  int          checks = 0;
  int          failures = 0;
  bit          final_req = 1'b0;
  bit          final_done = 1'b0;
  logic [14:0] act;

  assign act = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
                ALU_Sel, Bus1_Sel, Bus2_Sel, write};

  // {IR_Load,MAR_Load,PC_Load,PC_Inc,A_Load,B_Load,CCR_Load,ALU_Sel,Bus1_Sel,Bus2_Sel,write}
  function automatic logic [14:0] mk(bit irl, bit marl, bit pcl, bit pci, bit al, bit bl,
                                     bit ccl, bit [2:0] alu, bit [1:0] b1, bit [1:0] b2, bit wr);
    return {irl, marl, pcl, pci, al, bl, ccl, alu, b1, b2, wr};
  endfunction

  // Returns {valid, dest_is_b, alu_sel} from the ALU opcode table.
  function automatic logic [4:0] alu_entry(input logic [7:0] op);
    case (op)
      8'h42: return 5'b1_0_000;
      8'h43: return 5'b1_0_001;
      8'h44: return 5'b1_0_010;
      8'h45: return 5'b1_0_011;
      8'h4A: return 5'b1_0_110;
      8'h46: return 5'b1_0_100;
      8'h48: return 5'b1_0_101;
      8'h4B: return 5'b1_0_111;
      8'h47: return 5'b1_1_100;
      8'h49: return 5'b1_1_101;
      8'h4C: return 5'b1_1_111;
      default: return 5'b0_0_000;
    endcase
  endfunction

  task automatic model(input logic [7:0] op, input logic [3:0] ccr);
    logic [14:0] mar_pc, pc_inc, zero;
    logic [4:0]  ae;
    bit          isb, taken;
    int          idx;
    zero   = '0;
    mar_pc = mk(0, 1, 0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd1, 0);
    pc_inc = mk(0, 0, 0, 1, 0, 0, 0, 3'd0, 2'd0, 2'd0, 0);
    isb    = (op == 8'h88 || op == 8'h89 || op == 8'h97);
    ae     = alu_entry(op);
    seq.delete();
    seq.push_back(mar_pc);
    seq.push_back(pc_inc);
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd2, 0));
    seq.push_back(zero);
    if (op == 8'h86 || op == 8'h88) begin
      seq.push_back(mar_pc);
      seq.push_back(pc_inc);
      seq.push_back(mk(0, 0, 0, 0, !isb, isb, 0, 3'd0, 2'd0, 2'd2, 0));
    end else if (op == 8'h87 || op == 8'h89) begin
      seq.push_back(mar_pc);
      seq.push_back(pc_inc);
      seq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd2, 0));
      seq.push_back(zero);
      seq.push_back(mk(0, 0, 0, 0, !isb, isb, 0, 3'd0, 2'd0, 2'd2, 0));
    end else if (op == 8'h96 || op == 8'h97) begin
      seq.push_back(mar_pc);
      seq.push_back(pc_inc);
      seq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd2, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'd0, isb ? 2'd2 : 2'd1, 2'd0, 1));
    end else if (ae[4]) begin
      seq.push_back(mk(0, 0, 0, 0, !ae[3], ae[3], 1, ae[2:0], ae[3] ? 2'd2 : 2'd1, 2'd0, 0));
    end else if (op >= 8'h20 && op <= 8'h28) begin
      idx   = int'(op) - 8'h21;
`ifdef CU_COND_BRANCH_EN
      taken = (op == 8'h20) || ((idx % 2 == 0) ? ccr[3 - idx / 2] : !ccr[3 - idx / 2]);
`else
      taken = (op == 8'h20) || (ccr == 4'hF && idx < 0);
`endif
      if (taken) begin
        seq.push_back(mar_pc);
        seq.push_back(zero);
        seq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 2'd2, 0));
      end else begin
        seq.push_back(pc_inc);
      end
    end
  endtask

  task automatic push_exp(input logic [14:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      push_exp('0, "rst_hold");
      @(posedge clk); #1;
    end
    reset = 1'b0;
    push_exp('0, "rst_release");
    @(posedge clk); #1;
  endtask

  // Drives one instruction from its F0 cycle; cut >= 0 asserts reset mid-cycle at that index.
  task automatic issue(input logic [7:0] op, input logic [3:0] ccr, input int cut);
    model(op, ccr);
    for (int k = 0; k < seq.size(); k++) begin
      if (k == cut) begin
        push_exp('0, $sformatf("async_rst_op%02h_c%0d", op, k));
        break;
      end
      push_exp(seq[k], $sformatf("op%02h_ccr%h_c%0d", op, ccr, k));
    end
    for (int k = 0; k < seq.size(); k++) begin
      IR = op;
      CCR_Result = (k == 3) ? ccr : 4'($urandom);
      if (k == cut) begin
        #1 reset = 1'b1;
        @(posedge clk); #1;
        hold_reset(1);
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    checks++;
    if ((write && (IR_Load || MAR_Load || PC_Load || A_Load || B_Load || CCR_Load)) ||
        (PC_Inc && PC_Load)) begin
      failures++;
      $display("FAIL strobe_exclusion actual=%h required=no write+load, no PC_Inc+PC_Load", act);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s actual=%b required=%b", e.tag, act, e.v);
      end
    end else if (final_req && !final_done) begin
      final_done = 1'b1;
      checks++;
      if (reset !== 1'b0) begin
        failures++;
        $display("FAIL final_state actual reset=%b required=0", reset);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] defined_ops [0:27];
    logic [7:0] op;
    int         cut;
    defined_ops = '{8'h86, 8'h88, 8'h87, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43, 8'h44, 8'h45,
                    8'h4A, 8'h46, 8'h48, 8'h4B, 8'h47, 8'h49, 8'h4C, 8'h20, 8'h21, 8'h22,
                    8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'hFF, 8'h00};
    reset = 1'b1;
    IR = 8'h00;
    CCR_Result = 4'h0;
    @(posedge clk); #1;
    hold_reset(2);

    issue(8'h86, 4'h0, -1);
    issue(8'h96, 4'h0, -1);
    issue(8'h47, 4'h0, -1);
    issue(8'h23, 4'b0100, -1);
    issue(8'h23, 4'b0000, -1);
    issue(8'hFF, 4'h0, -1);
    issue(8'h89, 4'h0, -1);
    issue(8'h20, 4'h0, -1);
    issue(8'h96, 4'h0, 7);
    issue(8'h4B, 4'h0, -1);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else op = defined_ops[$urandom_range(0, 27)];
      cut = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : -1;
      issue(op, 4'($urandom), cut);
    end

    final_req = 1'b1;
    wait (exp_q.size() == 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
